qam_demapper_gen2: RTL
======================

# qam_demapper_gen2

Parametrised, streaming hard-decision QAM demapper: the successor to the fixed 16-QAM demapper.
- Accepts signed I/Q samples with a valid/ready handshake.
- Removes a calibrated DC offset, slices each axis for QPSK, 16-QAM or 64-QAM.
- Gray-decodes each axis and buffers symbols in a FIFO.
- Serialises the bits MSB-first on a valid/ready bit stream.

It sits between the front-end sample source and the downstream bit consumer.

## Interface
Parameters:
- IN_W, 8: width of signed I/Q samples.
- FIFO_DEPTH, 8: symbol FIFO entries (power of two, ≥4).
- CAL_LOG2, 4: calibration averages 2^CAL_LOG2 samples.

Ports:
- dclk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- mode  in  2  0 QPSK, 1 16-QAM, 2 64-QAM, 3 reserved (treated as 16-QAM); sampled per accepted symbol.
- i_in, q_in  in  IN_W  signed samples.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- cal_start  in  1  pulse: begin offset calibration.
- cal_busy  out  1  high while in CAL.
- cal_done  out  1  one-cycle pulse when new offsets take effect.
- dout  out  1  serial data bit.
- dout_valid  out  1  dout valid.
- dout_ready  in  1  bit consumed when dout_valid && dout_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: all outputs 0, except in_ready, which rises in the first cycle after reset if space is available. Offsets are 0 and the FSM is in RUN.
- FSM states:
  - RUN: accepted samples are demapped.
  - CAL: entered on cal_start in RUN. in_ready=1, and accepted samples go only to two accumulators of width IN_W+CAL_LOG2. After 2^CAL_LOG2 accepted samples, offset = sum >>> CAL_LOG2 (arithmetic, floor). cal_done pulses and the FSM returns to RUN. cal_start in CAL is ignored.
- Centering: x = sample − offset, computed at IN_W+1 bits, then saturated to [−2^(IN_W−1), 2^(IN_W−1)−1].
- Slicing: b bits per axis, where b = 1/2/3 for QPSK/16/64-QAM.
  - Level index k = (x + 2^(IN_W−1)) >> (IN_W−b).
  - Uniform thresholds; a value exactly on a threshold goes to the upper level.
- Gray decode per axis: g = k ^ (k>>1).
- Symbol word: {gI, gQ}, 2b bits, MSB first. Each FIFO entry stores the word (6 bits) plus its mode.
- Serializer: loads from the FIFO when it is empty, or in the same cycle its last bit handshakes. This gives back-to-back symbols with no bubble.
- Mode changes take effect at the next accepted sample; words already in flight keep the mode they were accepted with.
- in_ready (RUN) = fifo_level + in-flight pipeline entries < FIFO_DEPTH. No overflow is possible.
- During CAL, the pipeline, FIFO and serializer keep draining. Samples already in flight use the old offset.
- Reset mid-operation (calibration, serialization or FIFO contents) clears everything immediately.

## Timing
- Pipeline: stage 1 (center + saturate) → stage 2 (slice + Gray) → FIFO write.
- Sample accepted at edge N: FIFO write at N+2, dout_valid at N+3 if the serializer is idle and the FIFO is empty.
- A 2b-bit symbol occupies exactly 2b accepted dout handshakes.
- cal_done is asserted the cycle after the final calibration sample is accepted; offsets apply from that cycle.
- in_ready is combinational from registered state only (no path from in_valid or dout_ready).

## Structure
- Package qam_pkg holds:
  - mode enum (MODE_QPSK, MODE_16, MODE_64).
  - function bits_per_axis(mode).
  - function gray(k).
  - MAX_WORD_W = 6.
- One sub-module: qam_sym_fifo. It is a synchronous FIFO of {mode, word}, FIFO_DEPTH deep, with level output and simultaneous read/write allowed when full or empty.

## Test plan
- 16-QAM, I=100, Q=−20, dout_ready=1 → dout 1,0,0,1 starting edge N+3, then dout_valid=0.
- 64-QAM, I=−128, Q=127 → 0,0,0,1,0,0. QPSK, I=5, Q=−5 → 1,0. All three sent back-to-back with mode changes per sample → 12 contiguous bits with no gaps.
- cal_start, then 16 samples I=10, Q=−6 → cal_done pulse, offsets 10/−6. Next 16-QAM sample I=0, Q=0 → centered −10/6 → dout 0,1,1,1.
- Saturation: calibrate to I offset −100, then I=100 (16-QAM) → x clamps to 127 → gI=10.
- Threshold: 16-QAM I=64, Q=0 → kI=3, kQ=2 → 1,0,1,1.
- Backpressure: dout_ready=0, stream in_valid=1 → fifo_level reaches 8, in_ready drops, no sample lost. Assert rst low mid-stream → all outputs 0, fifo_level 0.

Source files
------------

// File: rtl/qam_demapper_gen2_pkg.sv
// Shared types and helpers for the gen2 QAM demapper: constellation modes,
// per-axis bit counts and the Gray decoding used when slicing each axis.
package qam_pkg;

    localparam int MAX_WORD_W = 6;
    localparam int MODE_W     = 2;
    localparam int ENTRY_W    = MODE_W + MAX_WORD_W;

    typedef enum logic [1:0] {
        MODE_QPSK = 2'd0,
        MODE_16   = 2'd1,
        MODE_64   = 2'd2
    } mode_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_CAL = 1'b1
    } cal_state_t;

    // Symbol words are kept left-aligned so the serializer always shifts out the top bit.
    typedef struct packed {
        mode_t                   mode;
        logic [MAX_WORD_W-1:0]   word;
    } sym_entry_t;

    // The reserved encoding behaves as 16-QAM.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd0:    return MODE_QPSK;
            2'd2:    return MODE_64;
            default: return MODE_16;
        endcase
    endfunction

    function automatic logic [1:0] bits_per_axis(input mode_t m);
        case (m)
            MODE_QPSK: return 2'd1;
            MODE_64:   return 2'd3;
            default:   return 2'd2;
        endcase
    endfunction

    function automatic logic [2:0] gray(input logic [2:0] k);
        return k ^ (k >> 1);
    endfunction

endpackage

// File: rtl/qam_demapper_gen2_fifo.sv
// Synchronous show-ahead FIFO of demapped symbol entries with an occupancy count;
// a write is still taken when full as long as a read happens in the same cycle.
module qam_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     dclk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the pointers and level decide what is valid.
    always_ff @(posedge dclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/qam_demapper_gen2.sv
// Streaming hard-decision QPSK/16/64-QAM demapper with DC-offset calibration,
// a two-stage slicing pipeline, a symbol FIFO and an MSB-first bit serializer.
module qam_demapper_gen2
    import qam_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CAL_LOG2   = 4
) (
    input  logic                           dclk,
    input  logic                           rst,
    input  logic [1:0]                     mode,
    input  logic [IN_W-1:0]                i_in,
    input  logic [IN_W-1:0]                q_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           cal_start,
    output logic                           cal_busy,
    output logic                           cal_done,
    output logic                           dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ACC_W = IN_W + CAL_LOG2;

    cal_state_t            state;
    cal_state_t            state_next;
    logic                  cal_last;
    logic                  ready_en;
    logic                  accept;
    logic                  run_accept;
    logic [LVL_W:0]        occupancy;

    logic [ACC_W-1:0]      acc_i;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      sum_i;
    logic [ACC_W-1:0]      sum_q;
    logic [CAL_LOG2-1:0]   cal_cnt;
    logic [IN_W-1:0]       off_i;
    logic [IN_W-1:0]       off_q;

    logic [IN_W:0]         diff_i;
    logic [IN_W:0]         diff_q;
    logic                  s1_valid;
    logic [IN_W-1:0]       s1_x_i;
    logic [IN_W-1:0]       s1_x_q;
    mode_t                 s1_mode;

    logic [IN_W-1:0]       biased_i;
    logic [IN_W-1:0]       biased_q;
    int                    shamt;
    logic [2:0]            k_i;
    logic [2:0]            k_q;
    logic [2:0]            g_i;
    logic [2:0]            g_q;
    logic [MAX_WORD_W-1:0] slice_word;
    logic                  s2_valid;
    sym_entry_t            s2_entry;

    logic [ENTRY_W-1:0]    fifo_wr_data;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    sym_entry_t            fifo_rd;
    logic                  fifo_empty;
    logic                  ser_load;
    logic [MAX_WORD_W-1:0] shreg;
    logic [2:0]            bits_left;

    // Clamp an IN_W+1 bit difference back into the signed IN_W range.
    function automatic logic [IN_W-1:0] saturate(input logic [IN_W:0] d);
        if (d[IN_W] != d[IN_W-1]) return {d[IN_W], {(IN_W-1){~d[IN_W]}}};
        return d[IN_W-1:0];
    endfunction

    // Occupancy counts pipeline entries too, so a full FIFO can never be overrun.
    assign occupancy  = {1'b0, fifo_level} + {{LVL_W{1'b0}}, s1_valid} + {{LVL_W{1'b0}}, s2_valid};
    assign in_ready   = ready_en && ((state == ST_CAL) || (occupancy < (LVL_W+1)'(FIFO_DEPTH)));
    assign accept     = in_valid && in_ready;
    assign run_accept = accept && (state == ST_RUN);
    assign cal_busy   = (state == ST_CAL);

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cal_last   = 1'b0;
        unique case (state)
            ST_RUN: if (cal_start) state_next = ST_CAL;
            ST_CAL: begin
                if (accept && (cal_cnt == {CAL_LOG2{1'b1}})) begin
                    cal_last   = 1'b1;
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    assign sum_i = acc_i + {{CAL_LOG2{i_in[IN_W-1]}}, i_in};
    assign sum_q = acc_q + {{CAL_LOG2{q_in[IN_W-1]}}, q_in};

    // Taking the top IN_W bits of the sum is the floor division by the sample count.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            acc_i    <= '0;
            acc_q    <= '0;
            cal_cnt  <= '0;
            off_i    <= '0;
            off_q    <= '0;
            cal_done <= 1'b0;
        end else begin
            cal_done <= cal_last;
            if (state == ST_RUN) begin
                acc_i   <= '0;
                acc_q   <= '0;
                cal_cnt <= '0;
            end else if (accept) begin
                acc_i   <= sum_i;
                acc_q   <= sum_q;
                cal_cnt <= cal_cnt + CAL_LOG2'(1);
                if (cal_last) begin
                    off_i <= sum_i[ACC_W-1:CAL_LOG2];
                    off_q <= sum_q[ACC_W-1:CAL_LOG2];
                end
            end
        end
    end

    assign diff_i = {i_in[IN_W-1], i_in} - {off_i[IN_W-1], off_i};
    assign diff_q = {q_in[IN_W-1], q_in} - {off_q[IN_W-1], off_q};

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_x_i   <= '0;
            s1_x_q   <= '0;
            s1_mode  <= MODE_QPSK;
        end else begin
            s1_valid <= run_accept;
            if (run_accept) begin
                s1_x_i  <= saturate(diff_i);
                s1_x_q  <= saturate(diff_q);
                s1_mode <= decode_mode(mode);
            end
        end
    end

    // Adding half-scale to a two's complement value is just flipping its sign bit.
    assign biased_i = {~s1_x_i[IN_W-1], s1_x_i[IN_W-2:0]};
    assign biased_q = {~s1_x_q[IN_W-1], s1_x_q[IN_W-2:0]};

    always_comb begin
        shamt      = IN_W - int'(bits_per_axis(s1_mode));
        k_i        = 3'(biased_i >> shamt);
        k_q        = 3'(biased_q >> shamt);
        g_i        = gray(k_i);
        g_q        = gray(k_q);
        slice_word = '0;
        unique case (s1_mode)
            MODE_QPSK: slice_word = {g_i[0], g_q[0], 4'b0000};
            MODE_64:   slice_word = {g_i, g_q};
            default:   slice_word = {g_i[1:0], g_q[1:0], 2'b00};
        endcase
    end

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry.mode <= s1_mode;
                s2_entry.word <= slice_word;
            end
        end
    end

    assign fifo_wr_data = s2_entry;
    assign fifo_rd      = sym_entry_t'(fifo_rd_data);

    qam_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .dclk    (dclk),
        .rst     (rst),
        .wr_en   (s2_valid),
        .wr_data (fifo_wr_data),
        .rd_en   (ser_load),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Reload on the last bit's handshake so consecutive symbols leave with no gap.
    assign dout_valid = (bits_left != 3'd0);
    assign dout       = shreg[MAX_WORD_W-1];
    assign ser_load   = !fifo_empty && (!dout_valid || (dout_ready && (bits_left == 3'd1)));

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            bits_left <= '0;
        end else if (ser_load) begin
            shreg     <= fifo_rd.word;
            bits_left <= {bits_per_axis(fifo_rd.mode), 1'b0};
        end else if (dout_valid && dout_ready) begin
            shreg     <= {shreg[MAX_WORD_W-2:0], 1'b0};
            bits_left <= bits_left - 3'd1;
        end
    end

endmodule
